control_unit: RTL and testbench

//   Instruction decoder for the 8-bit single-cycle processor. Splits a 10-bit

---
 rtl/cu_pkg.sv | 64 ++++++
 rtl/cu_decode.sv | 98 +++++++++
 rtl/control_unit.sv | 77 +++++++
 tb/tb_control_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// ----------------------------------------------------------------------------
// cu_pkg
//   Shared definitions for the processor control unit: instruction field
//   widths, opcode values, function-unit (g_select) codes, B-operand mux
//   (mb_select) codes and the bundled control word passed from the decoder
//   to the output register bank.
// ----------------------------------------------------------------------------
package cu_pkg;

    localparam int CU_INSTR_W  = 10;
    localparam int CU_DATA_W   = 8;
    localparam int CU_NUM_REGS = 8;
    localparam int CU_OP_W     = 4;
    localparam int CU_SEL_W    = 3;

    // Opcodes (instruction[9:6])
    localparam logic [CU_OP_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [CU_OP_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [CU_OP_W-1:0] OP_ADDI  = 4'b0010;
    localparam logic [CU_OP_W-1:0] OP_SUBI  = 4'b0011;
    localparam logic [CU_OP_W-1:0] OP_MUL2  = 4'b0100;
    localparam logic [CU_OP_W-1:0] OP_DIV2  = 4'b0101;
    localparam logic [CU_OP_W-1:0] OP_CLR   = 4'b0110;
    localparam logic [CU_OP_W-1:0] OP_RST   = 4'b0111;
    localparam logic [CU_OP_W-1:0] OP_MOV   = 4'b1000;
    localparam logic [CU_OP_W-1:0] OP_JMP   = 4'b1001;
    localparam logic [CU_OP_W-1:0] OP_OUT   = 4'b1010;
    localparam logic [CU_OP_W-1:0] OP_LOAD  = 4'b1011;
    localparam logic [CU_OP_W-1:0] OP_STORE = 4'b1100;

    // Function-unit codes
    localparam logic [3:0] G_PASS_A = 4'b0000;
    localparam logic [3:0] G_ADD    = 4'b0001;
    localparam logic [3:0] G_SUB    = 4'b0010;
    localparam logic [3:0] G_SHL    = 4'b0011;
    localparam logic [3:0] G_SHR    = 4'b0100;
    localparam logic [3:0] G_PASS_B = 4'b0101;

    // B-operand mux codes
    localparam logic [1:0] MB_REG   = 2'b00;
    localparam logic [1:0] MB_CONST = 2'b01;
    localparam logic [1:0] MB_ZERO  = 2'b10;

    typedef struct packed {
        logic [CU_SEL_W-1:0]    reg_a_select;
        logic [CU_SEL_W-1:0]    reg_b_select;
        logic [CU_NUM_REGS-1:0] write_enable;
        logic [3:0]             g_select;
        logic                   mem_read;
        logic                   mem_write;
        logic [1:0]             mb_select;
        logic                   mf_select;
        logic                   md_select;
        logic                   load;
        logic [CU_DATA_W-1:0]   set_value;
        logic [CU_DATA_W-1:0]   constant_in;
    } cu_ctrl_t;

    // One-hot register write strobe for destination field A
    function automatic logic [CU_NUM_REGS-1:0] onehot(input logic [CU_SEL_W-1:0] sel);
        onehot = CU_NUM_REGS'(1) << sel;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// ----------------------------------------------------------------------------
// cu_decode
//   Purely combinational opcode decoder.
//   Ports:
//     instruction  in   10-bit instruction word {opcode, field A, field B}
//     ctrl         out  decoded control word (cu_ctrl_t)
// ----------------------------------------------------------------------------
module cu_decode
    import cu_pkg::*;
(
    input  logic [CU_INSTR_W-1:0] instruction,
    output cu_ctrl_t              ctrl
);

    logic [CU_OP_W-1:0]  opcode;
    logic [CU_SEL_W-1:0] field_a;
    logic [CU_SEL_W-1:0] field_b;

    assign opcode  = instruction[9:6];
    assign field_a = instruction[5:3];
    assign field_b = instruction[2:0];

    always_comb begin
        ctrl              = '0;
        ctrl.reg_a_select = field_a;
        ctrl.reg_b_select = field_b;

        case (opcode)
            OP_ADD: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_ADD;
                ctrl.mb_select    = MB_REG;
            end
            OP_SUB: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_SUB;
                ctrl.mb_select    = MB_REG;
            end
            OP_ADDI: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_ADD;
                ctrl.mb_select    = MB_CONST;
                ctrl.constant_in  = {5'b0, field_b};
            end
            OP_SUBI: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_SUB;
                ctrl.mb_select    = MB_CONST;
                ctrl.constant_in  = {5'b0, field_b};
            end
            OP_MUL2: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_SHL;
                ctrl.mf_select    = 1'b1;
            end
            OP_DIV2: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_SHR;
                ctrl.mf_select    = 1'b1;
            end
            OP_CLR: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_PASS_B;
                ctrl.mb_select    = MB_ZERO;
            end
            OP_RST: begin
                // Zero operand written into every register at once
                ctrl.write_enable = '1;
                ctrl.g_select     = G_PASS_B;
                ctrl.mb_select    = MB_ZERO;
            end
            OP_MOV: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.g_select     = G_PASS_B;
                ctrl.mb_select    = MB_REG;
            end
            OP_JMP: begin
                ctrl.load      = 1'b1;
                ctrl.set_value = {2'b0, instruction[5:0]};
            end
            OP_OUT: begin
                ctrl.g_select = G_PASS_A;
            end
            OP_LOAD: begin
                ctrl.write_enable = onehot(field_a);
                ctrl.mem_read     = 1'b1;
                ctrl.md_select    = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
            end
            default: begin
                // NOP: only the raw register selects pass through
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
//   Instruction decoder for the 8-bit single-cycle processor. The decoded
//   control word is registered, so every output reflects the instruction
//   presented on the previous rising clk edge. rst_n clears all outputs
//   asynchronously.
//   Ports:
//     clk, rst_n      clock (rising edge), async active-low reset
//     instruction     10-bit instruction word
//     reg_a_select    register-file read port A select (field A)
//     reg_b_select    register-file read port B select (field B)
//     write_enable    one-hot / all-ones register write strobe
//     g_select        function code
//     mem_read        data-memory read strobe
//     mem_write       data-memory write strobe
//     mb_select       B-operand mux select
//     mf_select       function unit select (0 ALU, 1 shifter)
//     md_select       writeback select (0 function unit, 1 memory)
//     load, set_value PC load strobe and value
//     constant_in     immediate operand
// ----------------------------------------------------------------------------
module control_unit
    import cu_pkg::*;
#(
    parameter int INSTR_W  = CU_INSTR_W,
    parameter int DATA_W   = CU_DATA_W,
    parameter int NUM_REGS = CU_NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  instruction,
    output logic [2:0]          reg_a_select,
    output logic [2:0]          reg_b_select,
    output logic [NUM_REGS-1:0] write_enable,
    output logic [3:0]          g_select,
    output logic                mem_read,
    output logic                mem_write,
    output logic [1:0]          mb_select,
    output logic                mf_select,
    output logic                md_select,
    output logic                load,
    output logic [DATA_W-1:0]   set_value,
    output logic [DATA_W-1:0]   constant_in
);

    cu_ctrl_t ctrl_p0;
    cu_ctrl_t ctrl_p1;

    // Stage 0: combinational decode
    cu_decode u_decode (
        .instruction (instruction),
        .ctrl        (ctrl_p0)
    );

    // Stage 1: output register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_p1 <= '0;
        end else begin
            ctrl_p1 <= ctrl_p0;
        end
    end

    assign reg_a_select = ctrl_p1.reg_a_select;
    assign reg_b_select = ctrl_p1.reg_b_select;
    assign write_enable = ctrl_p1.write_enable;
    assign g_select     = ctrl_p1.g_select;
    assign mem_read     = ctrl_p1.mem_read;
    assign mem_write    = ctrl_p1.mem_write;
    assign mb_select    = ctrl_p1.mb_select;
    assign mf_select    = ctrl_p1.mf_select;
    assign md_select    = ctrl_p1.md_select;
    assign load         = ctrl_p1.load;
    assign set_value    = ctrl_p1.set_value;
    assign constant_in  = ctrl_p1.constant_in;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [9:0] instruction;
    logic [2:0] reg_a_select;
    logic [2:0] reg_b_select;
    logic [7:0] write_enable;
    logic [3:0] g_select;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mb_select;
    logic       mf_select;
    logic       md_select;
    logic       load;
    logic [7:0] set_value;
    logic [7:0] constant_in;

    int tests_run = 0;
    int tests_failed = 0;

    control_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instruction  (instruction),
        .reg_a_select (reg_a_select),
        .reg_b_select (reg_b_select),
        .write_enable (write_enable),
        .g_select     (g_select),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mb_select    (mb_select),
        .mf_select    (mf_select),
        .md_select    (md_select),
        .load         (load),
        .set_value    (set_value),
        .constant_in  (constant_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every output against a hand-computed expectation
    task automatic chk_all(input string tag,
                           input logic [2:0] ra, input logic [2:0] rb,
                           input logic [7:0] we, input logic [3:0] g,
                           input logic mr, input logic mw,
                           input logic [1:0] mb, input logic mf, input logic md,
                           input logic ld, input logic [7:0] sv, input logic [7:0] ci);
        chk({tag, ".reg_a"},       32'(reg_a_select), 32'(ra));
        chk({tag, ".reg_b"},       32'(reg_b_select), 32'(rb));
        chk({tag, ".we"},          32'(write_enable), 32'(we));
        chk({tag, ".g"},           32'(g_select),     32'(g));
        chk({tag, ".mem_read"},    32'(mem_read),     32'(mr));
        chk({tag, ".mem_write"},   32'(mem_write),    32'(mw));
        chk({tag, ".mb"},          32'(mb_select),    32'(mb));
        chk({tag, ".mf"},          32'(mf_select),    32'(mf));
        chk({tag, ".md"},          32'(md_select),    32'(md));
        chk({tag, ".load"},        32'(load),         32'(ld));
        chk({tag, ".set_value"},   32'(set_value),    32'(sv));
        chk({tag, ".constant_in"}, 32'(constant_in),  32'(ci));
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge
    task automatic apply(input logic [9:0] instr);
        @(negedge clk);
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = 10'h3FF;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_hold", 3'd0, 3'd0, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;

        //            tag      instruction       ra    rb    we     g     mr mw mb    mf md ld sv     ci
        apply(10'b0000_000_101);
        chk_all("ADD",   3'd0, 3'd5, 8'h01, 4'h1, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);
        apply(10'b0001_010_001);
        chk_all("SUB",   3'd2, 3'd1, 8'h04, 4'h2, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);
        apply(10'b0010_101_011);
        chk_all("ADDI",  3'd5, 3'd3, 8'h20, 4'h1, 0, 0, 2'd1, 0, 0, 0, 8'h00, 8'h03);
        apply(10'b0011_111_111);
        chk_all("SUBI",  3'd7, 3'd7, 8'h80, 4'h2, 0, 0, 2'd1, 0, 0, 0, 8'h00, 8'h07);
        apply(10'b0100_110_100);
        chk_all("MUL2",  3'd6, 3'd4, 8'h40, 4'h3, 0, 0, 2'd0, 1, 0, 0, 8'h00, 8'h00);
        apply(10'b0101_101_100);
        chk_all("DIV2",  3'd5, 3'd4, 8'h20, 4'h4, 0, 0, 2'd0, 1, 0, 0, 8'h00, 8'h00);
        apply(10'b0110_011_000);
        chk_all("CLR",   3'd3, 3'd0, 8'h08, 4'h5, 0, 0, 2'd2, 0, 0, 0, 8'h00, 8'h00);
        apply(10'b0111_000_000);
        chk_all("RST",   3'd0, 3'd0, 8'hFF, 4'h5, 0, 0, 2'd2, 0, 0, 0, 8'h00, 8'h00);
        apply(10'b1000_001_010);
        chk_all("MOV",   3'd1, 3'd2, 8'h02, 4'h5, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);
        apply(10'b1001_000_111);
        chk_all("JMP",   3'd0, 3'd7, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0, 1, 8'h07, 8'h00);
        apply(10'b1001_111_111);
        chk_all("JMPMAX",3'd7, 3'd7, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0, 1, 8'h3F, 8'h00);
        apply(10'b1010_110_000);
        chk_all("OUT",   3'd6, 3'd0, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);
        apply(10'b1011_101_001);
        chk_all("LOAD",  3'd5, 3'd1, 8'h20, 4'h0, 1, 0, 2'd0, 0, 1, 0, 8'h00, 8'h00);
        apply(10'b1100_100_110);
        chk_all("STORE", 3'd4, 3'd6, 8'h00, 4'h0, 0, 1, 2'd0, 0, 0, 0, 8'h00, 8'h00);
        apply(10'b1101_010_011);
        chk_all("NOP13", 3'd2, 3'd3, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);
        apply(10'h3FF);
        chk_all("NOP3FF",3'd7, 3'd7, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);

        // Output must hold the previous decode until the next edge
        @(negedge clk);
        instruction = 10'b0111_000_000;
        #1;
        chk("hold_before_edge.we", 32'(write_enable), 32'h00);
        @(posedge clk);
        #1;
        chk("RST_again.we", 32'(write_enable), 32'hFF);

        // Asynchronous clear in mid-cycle, well before any clock edge
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_clr", 3'd0, 3'd0, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0, 0, 8'h00, 8'h00);

        // Still cleared across an edge while held in reset
        @(posedge clk);
        #1;
        chk("reset_across_edge.we", 32'(write_enable), 32'h00);

        // First decode after release lands on the next rising edge
        @(negedge clk);
        rst_n = 1'b1;
        instruction = 10'b0010_101_011;
        #1;
        chk("after_release_pre_edge.ci", 32'(constant_in), 32'h00);
        @(posedge clk);
        #1;
        chk_all("after_release", 3'd5, 3'd3, 8'h20, 4'h1, 0, 0, 2'd1, 0, 0, 0, 8'h00, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
